ram_access_master: RTL and testbench
====================================

Name: ram_access_master

Overview:
- Initiator-side controller that drives one port of the 16-bit dual-port frame/data RAM (19-bit word address, 2-bit byte enable, configurable read latency).
- Accepts byte-addressed byte/halfword load/store requests over a valid/ready handshake.
- Maps each request onto RAM word accesses, splitting unaligned halfwords into two accesses, and returns formatted read data with a response-valid pulse.
- Sits between a CPU/DMA-style requester and RAM port A or B.

Parameters:
- READ_LATENCY, 2, cycles from address presented on ram_address to data valid on ram_q; legal 1..3.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  1  0 = byte, 1 = halfword
- req_addr  input  20  byte address
- req_wdata  input  16  store data; byte stores use [7:0]
- rsp_valid  output  1  one-cycle pulse, load data valid
- rsp_rdata  output  16  load result
- ram_address  output  19  RAM word address, registered
- ram_byteena  output  2  bit0 = [7:0], bit1 = [15:8], registered
- ram_data  output  16  RAM write data, registered
- ram_wren  output  1  RAM write enable, registered
- ram_q  input  16  RAM read data

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous, active-high.
- Little-endian: the even byte address is in word[7:0], the odd byte address in word[15:8]. Word address = req_addr[19:1]; lane = req_addr[0].
- Reset (rst sampled high at an edge):
  - State goes to IDLE.
  - ram_address = 0, ram_byteena = 2'b00, ram_data = 0, ram_wren = 0.
  - rsp_valid = 0, rsp_rdata = 0, latency counter = 0.
  - req_ready = 0 while rst is high.
- Reset mid-operation: pending split accesses and pending read responses are discarded; no rsp_valid is issued for them.
- States:
  - IDLE: req_ready = 1. Acceptance occurs on req_valid && req_ready at edge E0.
  - ACC1: first access presented during cycle E0+1.
  - ACC2: second access; entered only for a split (req_size = 1 && lane = 1).
  - WAIT: load only; counts READ_LATENCY cycles per access and captures ram_q.
  - RESP: rsp_valid pulses; returns to IDLE.
- Access encoding:
  - Byte store: byteena = 01 for lane 0, 10 for lane 1; ram_data = {wdata[7:0], wdata[7:0]}.
  - Aligned half store: byteena = 11; ram_data = wdata.
  - Split store: access 1 is word n, byteena 10, data {wdata[7:0], wdata[7:0]}; access 2 is word n+1, byteena 01, data {wdata[15:8], wdata[15:8]}.
  - Loads: ram_wren = 0, byteena = 11.
  - Word n+1 wraps modulo 2^19, so 19'h7FFFF + 1 = 19'h00000.
  - Outside active access cycles: ram_wren = 0, byteena = 00, ram_address holds its last value.
- Timing, with t = the accept cycle and L = READ_LATENCY:
  - Aligned store: RAM access in cycle t+1; req_ready high again in t+2.
  - Split store: RAM accesses in t+1 and t+2; req_ready high in t+3.
  - Aligned load: address in t+1; ram_q sampled in cycle t+1+L; rsp_valid in t+2+L, with req_ready high in the same cycle.
  - Split load: second address in t+2; second ram_q sampled in t+2+L; rsp_valid in t+3+L.
  - Stores produce no rsp_valid.
- Load formatting:
  - Byte load: rsp_rdata = {8'h00, selected byte}.
  - Aligned half load: rsp_rdata = q.
  - Split half load: rsp_rdata = {q2[7:0], q1[15:8]}.
  - rsp_rdata holds its value until the next response.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. req_valid while busy is ignored, and the requester holds it.

Test Plan:
- Byte store, addr 20'h00001, wdata 16'h00AB -> cycle t+1: ram_address 0, byteena 10, ram_data 16'hABAB, wren 1; req_ready high at t+2.
- Aligned half load, addr 20'h00000, RAM word0 = 16'hEEAA, L = 2 -> rsp_valid at t+4, rsp_rdata 16'hEEAA.
- Split half load, addr 20'h00003, word1 = 16'h1122, word2 = 16'h3344 -> addresses 1 then 2; rsp_rdata 16'h4411 at t+5.
- Split store at addr 20'hFFFFF, wdata 16'hBEEF -> word 7FFFF byteena 10 data EFEF, then word 00000 byteena 01 data BEBE.
- Byte load at addr 20'h00002, word1 = 16'h1122, then rst high during WAIT -> no rsp_valid; all RAM outputs 0 on the next edge; req_ready 1 one cycle after rst drops.
- Back-to-back loads with L = 1 and L = 3 -> each rsp_valid at the computed cycle; req_valid held while busy is not double-accepted.

Source files
------------

// File: rtl/ram_access_master_if.sv
// ---------------------------------------------------------------------------
// ram_access_master_if
// Bundles the request/response handshake and the RAM port of
// ram_access_master.
//   master : environment side (requester drives req_*, RAM model drives ram_q)
//   slave  : ram_access_master side
// Signals:
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_size             0 = byte, 1 = halfword
//   req_addr[19:0]       byte address
//   req_wdata[15:0]      store data (byte stores use [7:0])
//   rsp_valid            one-cycle pulse, load data valid
//   rsp_rdata[15:0]      load result, held until the next response
//   ram_address[18:0]    RAM word address
//   ram_byteena[1:0]     bit0 = [7:0], bit1 = [15:8]
//   ram_data[15:0]       RAM write data
//   ram_wren             RAM write enable
//   ram_q[15:0]          RAM read data
// ---------------------------------------------------------------------------
interface ram_access_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_size;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [18:0] ram_address;
    logic [1:0]  ram_byteena;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic [15:0] ram_q;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_rdata,
               ram_address, ram_byteena, ram_data, ram_wren
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_rdata,
               ram_address, ram_byteena, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_access_master.sv
// ---------------------------------------------------------------------------
// ram_access_master
// Initiator for one port of the 16-bit dual-port RAM. Turns byte-addressed
// byte/halfword loads and stores into RAM word accesses (an unaligned
// halfword becomes two accesses) and returns formatted load data.
// Parameters:
//   READ_LATENCY  cycles from ram_address to valid ram_q (1..3)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ram_access_master_if.slave (request, response and RAM signals)
// ---------------------------------------------------------------------------
module ram_access_master #(
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_access_master_if.slave    bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_ACC2 = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // Counter value (cycles since the first access) at which ram_q holds the
    // data of the first and the second access respectively.
    localparam logic [2:0] LAT  = 3'(READ_LATENCY);
    localparam logic [2:0] LAT1 = 3'(READ_LATENCY + 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic        lane_q, lane_d;
    logic [7:0]  whi_q, whi_d;
    logic [7:0]  q1_q, q1_d;
    logic [18:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] data_q, data_d;
    logic        wren_q, wren_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;

    logic        ready;
    logic        accept;
    logic        split;
    logic [2:0]  final_cnt;

    function automatic logic [15:0] format_load(input logic [15:0] q,
                                                input logic        size,
                                                input logic        lane,
                                                input logic [7:0]  q1_hi);
        logic [15:0] r;
        if (!size)
            r = {8'h00, (lane ? q[15:8] : q[7:0])};
        else if (lane)
            r = {q[7:0], q1_hi};
        else
            r = q;
        return r;
    endfunction

    // RESP also accepts so a new request can overlap the response pulse.
    assign ready     = !rst && ((state_q == S_IDLE) || (state_q == S_RESP));
    assign accept    = bus.req_valid && ready;
    assign split     = size_q && lane_q;
    assign final_cnt = split ? LAT1 : LAT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        lane_d      = lane_q;
        whi_d       = whi_q;
        q1_d        = q1_q;
        addr_d      = addr_q;
        be_d        = 2'b00;
        data_d      = data_q;
        wren_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        if (state_q != S_IDLE)
            cnt_d = cnt_q + 3'd1;

        case (state_q)
            S_IDLE: ;
            S_ACC1: begin
                if (split) begin
                    state_d = S_ACC2;
                    addr_d  = addr_q + 19'd1;   // wraps modulo 2^19
                    if (we_q) begin
                        be_d   = 2'b01;
                        data_d = {whi_q, whi_q};
                        wren_d = 1'b1;
                    end else begin
                        be_d   = 2'b11;
                    end
                end else begin
                    state_d = we_q ? S_IDLE : S_WAIT;
                end
            end
            S_ACC2: state_d = we_q ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (cnt_q == final_cnt) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = format_load(bus.ram_q, size_q, lane_q, q1_q);
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // First half of a split load; with READ_LATENCY = 1 this lands while
        // the second access is still being presented.
        if (split && !we_q && (cnt_q == LAT) &&
            ((state_q == S_ACC2) || (state_q == S_WAIT)))
            q1_d = bus.ram_q[15:8];

        if (accept) begin
            state_d = S_ACC1;
            cnt_d   = 3'd0;
            we_d    = bus.req_we;
            size_d  = bus.req_size;
            lane_d  = bus.req_addr[0];
            whi_d   = bus.req_wdata[15:8];
            addr_d  = bus.req_addr[19:1];
            if (bus.req_we) begin
                wren_d = 1'b1;
                if (bus.req_size && !bus.req_addr[0]) begin
                    be_d   = 2'b11;
                    data_d = bus.req_wdata;
                end else begin
                    // byte store, or first (upper-lane) half of a split store
                    be_d   = bus.req_addr[0] ? 2'b10 : 2'b01;
                    data_d = {bus.req_wdata[7:0], bus.req_wdata[7:0]};
                end
            end else begin
                be_d   = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 19'd0;
            be_q        <= 2'b00;
            data_q      <= 16'd0;
            wren_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request context; only meaningful while a transaction is active.
    always_ff @(posedge clk) begin
        we_q   <= we_d;
        size_q <= size_d;
        lane_q <= lane_d;
        whi_q  <= whi_d;
        q1_q   <= q1_d;
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_byteena = be_q;
    assign bus.ram_data    = data_q;
    assign bus.ram_wren    = wren_q;
endmodule

// File: tb/tb_ram_access_master.sv
// ---------------------------------------------------------------------------
// tb_ram_access_master
// Three ram_access_master instances (READ_LATENCY 1, 2, 3), each with its own
// small RAM model, driven by one directed sequence of requests.
// ---------------------------------------------------------------------------
module tb_ram_access_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid   [3];
    logic        req_we      [3];
    logic        req_size    [3];
    logic [19:0] req_addr    [3];
    logic [15:0] req_wdata   [3];
    logic        req_ready   [3];
    logic        rsp_valid   [3];
    logic [15:0] rsp_rdata   [3];
    logic [18:0] ram_address [3];
    logic [1:0]  ram_byteena [3];
    logic [15:0] ram_data    [3];
    logic        ram_wren    [3];

    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    for (genvar k = 0; k < 3; k++) begin : g
        ram_access_master_if ifc ();
        logic [15:0] mem [0:7];
        logic [15:0] qp  [0:2];

        assign ifc.req_valid = req_valid[k];
        assign ifc.req_we    = req_we[k];
        assign ifc.req_size  = req_size[k];
        assign ifc.req_addr  = req_addr[k];
        assign ifc.req_wdata = req_wdata[k];
        assign req_ready[k]   = ifc.req_ready;
        assign rsp_valid[k]   = ifc.rsp_valid;
        assign rsp_rdata[k]   = ifc.rsp_rdata;
        assign ram_address[k] = ifc.ram_address;
        assign ram_byteena[k] = ifc.ram_byteena;
        assign ram_data[k]    = ifc.ram_data;
        assign ram_wren[k]    = ifc.ram_wren;

        ram_access_master #(.READ_LATENCY(k + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );

        // RAM model: 8 words indexed by address[2:0], read data delayed k+1 cycles
        always @(posedge clk) begin
            qp[0] <= mem[ifc.ram_address[2:0]];
            qp[1] <= qp[0];
            qp[2] <= qp[1];
            if (pl_en) begin
                mem[pl_addr] <= pl_data;
            end else if (ifc.ram_wren) begin
                if (ifc.ram_byteena[0]) mem[ifc.ram_address[2:0]][7:0]  <= ifc.ram_data[7:0];
                if (ifc.ram_byteena[1]) mem[ifc.ram_address[2:0]][15:8] <= ifc.ram_data[15:8];
            end
        end
        assign ifc.ram_q = qp[k];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic do_req(input int k, input logic we, input logic size,
                          input logic [19:0] addr, input logic [15:0] wd, input bit hold);
        req_we[k] = we; req_size[k] = size; req_addr[k] = addr; req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        chk("ready_before_accept", 32'(req_ready[k]), 32'd1);
        step();
        if (!hold) req_valid[k] = 1'b0;
    endtask

    // n0 = cycle offset from the accept cycle at entry
    task automatic wait_rsp(input int k, input int n0, input int exp_n,
                            input logic [15:0] exp_d, input string tag);
        int n;
        n = n0;
        while (!rsp_valid[k] && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_cycle"}, 32'(n), 32'(exp_n));
        chk({tag, "_rdata"}, 32'(rsp_rdata[k]), 32'(exp_d));
        chk({tag, "_ready"}, 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        int  k;
        int  lat;
        bit  seen;

        rst = 1'b1;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 1'b0;
            req_addr[i] = 20'd0; req_wdata[i] = 16'd0;
        end
        step();
        step();
        preload(3'd0, 16'hEEAA);
        preload(3'd1, 16'h1122);
        preload(3'd2, 16'h3344);
        preload(3'd7, 16'h0000);

        // reset state
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready",   32'(req_ready[i]),   32'd0);
            chk("rst_addr",    32'(ram_address[i]), 32'd0);
            chk("rst_be",      32'(ram_byteena[i]), 32'd0);
            chk("rst_data",    32'(ram_data[i]),    32'd0);
            chk("rst_wren",    32'(ram_wren[i]),    32'd0);
            chk("rst_rspv",    32'(rsp_valid[i]),   32'd0);
            chk("rst_rdata",   32'(rsp_rdata[i]),   32'd0);
        end
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) chk("idle_ready", 32'(req_ready[i]), 32'd1);

        // aligned halfword load, word0 = EEAA, L = 2
        do_req(1, 1'b0, 1'b1, 20'h00000, 16'h0000, 1'b0);
        chk("ld_addr", 32'(ram_address[1]), 32'h0);
        chk("ld_be",   32'(ram_byteena[1]), 32'h3);
        chk("ld_wren", 32'(ram_wren[1]),    32'h0);
        chk("ld_busy", 32'(req_ready[1]),   32'h0);
        wait_rsp(1, 1, 4, 16'hEEAA, "ld_aligned");
        step();
        chk("rsp_pulse",  32'(rsp_valid[1]), 32'h0);
        chk("rdata_hold", 32'(rsp_rdata[1]), 32'hEEAA);

        // split halfword load at 3: words 1 then 2 -> 4411
        do_req(1, 1'b0, 1'b1, 20'h00003, 16'h0000, 1'b0);
        chk("sld_addr1", 32'(ram_address[1]), 32'h1);
        chk("sld_be1",   32'(ram_byteena[1]), 32'h3);
        step();
        chk("sld_addr2", 32'(ram_address[1]), 32'h2);
        chk("sld_be2",   32'(ram_byteena[1]), 32'h3);
        chk("sld_wren2", 32'(ram_wren[1]),    32'h0);
        wait_rsp(1, 2, 5, 16'h4411, "ld_split");

        // byte store to odd lane, accepted in the RESP cycle
        do_req(1, 1'b1, 1'b0, 20'h00001, 16'h00AB, 1'b0);
        chk("bst_addr",  32'(ram_address[1]), 32'h0);
        chk("bst_be",    32'(ram_byteena[1]), 32'h2);
        chk("bst_data",  32'(ram_data[1]),    32'hABAB);
        chk("bst_wren",  32'(ram_wren[1]),    32'h1);
        chk("bst_busy",  32'(req_ready[1]),   32'h0);
        step();
        chk("bst_ready", 32'(req_ready[1]),   32'h1);
        chk("bst_wren0", 32'(ram_wren[1]),    32'h0);
        chk("bst_be0",   32'(ram_byteena[1]), 32'h0);
        chk("bst_hold",  32'(ram_address[1]), 32'h0);
        chk("bst_norsp", 32'(rsp_valid[1]),   32'h0);
        do_req(1, 1'b0, 1'b1, 20'h00000, 16'h0000, 1'b0);
        wait_rsp(1, 1, 4, 16'hABAA, "ld_after_bst");

        // split store across the address wrap
        do_req(1, 1'b1, 1'b1, 20'hFFFFF, 16'hBEEF, 1'b0);
        chk("sst_addr1", 32'(ram_address[1]), 32'h7FFFF);
        chk("sst_be1",   32'(ram_byteena[1]), 32'h2);
        chk("sst_data1", 32'(ram_data[1]),    32'hEFEF);
        chk("sst_wren1", 32'(ram_wren[1]),    32'h1);
        step();
        chk("sst_addr2", 32'(ram_address[1]), 32'h00000);
        chk("sst_be2",   32'(ram_byteena[1]), 32'h1);
        chk("sst_data2", 32'(ram_data[1]),    32'hBEBE);
        chk("sst_wren2", 32'(ram_wren[1]),    32'h1);
        chk("sst_busy",  32'(req_ready[1]),   32'h0);
        step();
        chk("sst_ready", 32'(req_ready[1]),   32'h1);
        chk("sst_wren0", 32'(ram_wren[1]),    32'h0);
        chk("sst_norsp", 32'(rsp_valid[1]),   32'h0);
        do_req(1, 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 1'b0);
        wait_rsp(1, 1, 5, 16'hBEEF, "ld_wrap");

        // reset while waiting for load data
        do_req(1, 1'b0, 1'b0, 20'h00002, 16'h0000, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("mrst_addr",  32'(ram_address[1]), 32'h0);
        chk("mrst_be",    32'(ram_byteena[1]), 32'h0);
        chk("mrst_data",  32'(ram_data[1]),    32'h0);
        chk("mrst_wren",  32'(ram_wren[1]),    32'h0);
        chk("mrst_rspv",  32'(rsp_valid[1]),   32'h0);
        chk("mrst_ready", 32'(req_ready[1]),   32'h0);
        rst = 1'b0;
        step();
        chk("mrst_ready_after", 32'(req_ready[1]), 32'h1);
        seen = 1'b0;
        repeat (6) begin
            step();
            if (rsp_valid[1]) seen = 1'b1;
        end
        chk("mrst_no_rsp", 32'(seen), 32'h0);

        // byte loads from both lanes of word1 = 1122
        do_req(1, 1'b0, 1'b0, 20'h00002, 16'h0000, 1'b0);
        wait_rsp(1, 1, 4, 16'h0022, "ld_byte_lo");
        do_req(1, 1'b0, 1'b0, 20'h00003, 16'h0000, 1'b0);
        wait_rsp(1, 1, 4, 16'h0011, "ld_byte_hi");

        // back-to-back loads with req_valid held, L = 1 and L = 3
        for (int i = 0; i < 2; i++) begin
            k   = (i == 0) ? 0 : 2;
            lat = k + 1;
            do_req(k, 1'b0, 1'b1, 20'h00002, 16'h0000, 1'b1);
            req_addr[k] = 20'h00003;
            wait_rsp(k, 1, 2 + lat, 16'h1122, $sformatf("b2b_first_L%0d", lat));
            step();
            req_valid[k] = 1'b0;
            wait_rsp(k, 1, 3 + lat, 16'h4411, $sformatf("b2b_second_L%0d", lat));
            seen = 1'b0;
            repeat (8) begin
                step();
                if (rsp_valid[k]) seen = 1'b1;
            end
            chk($sformatf("b2b_no_double_L%0d", lat), 32'(seen), 32'h0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
